pipe_ctrl: RTL and testbench

Pipeline control unit for the CPU core. It generates per-stage stall and flush signals and the redirect `new_pc` consumed by the IF stage pipeline register and the downstream ID/EX/MEM registers. It sequences exception entry, interrupt entry and exception return (`eret`), and keeps the return address (`epc`) and the cause code. It sits beside the pipeline, fed by the bus interfaces (busy), the decoder (load hazard) and the MEM stage (exception, PC).

---
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall/flush generation and redirect sequencing
// for exception entry, interrupt entry and eret.
module pipe_ctrl #(
  parameter int unsigned          ADDR_W       = 30,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0]    EXC_VECTOR   = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              exc_req,
  input  logic [2:0]        exc_code_in,
  input  logic              eret_req,
  input  logic              irq,
  input  logic              int_en,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [2:0]        exc_code,
  output logic              int_active
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] IRQ_CODE = 3'd1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_new_pc;
  logic [ADDR_W-1:0] r_epc;
  logic [2:0]        r_exc_code;
  logic              r_int_active;

  logic w_stall;
  logic w_evt_ok;
  logic w_take_exc;
  logic w_take_eret;
  logic w_take_irq;

  assign w_stall = if_busy | mem_busy;

  // Events are only accepted from RUN with the MEM stage valid and advancing.
  assign w_evt_ok    = (r_state == RUN) & ~w_stall & mem_en;
  assign w_take_exc  = w_evt_ok & exc_req;
  assign w_take_eret = w_evt_ok & ~exc_req & eret_req;
  assign w_take_irq  = w_evt_ok & ~exc_req & ~eret_req & irq & int_en & ~r_int_active;

  always_comb begin
    w_next    = r_state;
    if_stall  = w_stall;
    id_stall  = w_stall;
    ex_stall  = w_stall;
    mem_stall = w_stall;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    case (r_state)
      RUN: begin
        if_stall = w_stall | ld_hazard;
        id_flush = ld_hazard & ~w_stall;
        if (w_take_exc | w_take_eret | w_take_irq) begin
          w_next = FLUSH;
        end
      end
      FLUSH: begin
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        if (!w_stall) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = RUN;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_new_pc     <= RESET_VECTOR;
      r_epc        <= '0;
      r_exc_code   <= '0;
      r_int_active <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take_exc) begin
        r_epc      <= mem_pc;
        r_exc_code <= exc_code_in;
        r_new_pc   <= EXC_VECTOR;
      end
      if (w_take_eret) begin
        r_new_pc     <= r_epc;
        r_int_active <= 1'b0;
      end
      // The interrupted instruction has not retired, so it re-executes on return.
      if (w_take_irq) begin
        r_epc        <= mem_pc;
        r_exc_code   <= IRQ_CODE;
        r_int_active <= 1'b1;
        r_new_pc     <= EXC_VECTOR;
      end
    end
  end

  assign new_pc     = r_new_pc;
  assign epc        = r_epc;
  assign exc_code   = r_exc_code;
  assign int_active = r_int_active;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl with a behavioural reference
// model and a redirect scoreboard drained by an independent monitor.
module tb_pipe_ctrl;

  localparam int AW = 30;
  localparam logic [AW-1:0] RV = '0;
  localparam logic [AW-1:0] EV = 30'h4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_busy, mem_busy, ld_hazard, mem_en;
  logic [AW-1:0] mem_pc;
  logic          exc_req;
  logic [2:0]    exc_code_in;
  logic          eret_req, irq, int_en;
  logic          if_stall, id_stall, ex_stall, mem_stall;
  logic          if_flush, id_flush, ex_flush, mem_flush;
  logic [AW-1:0] new_pc, epc;
  logic [2:0]    exc_code;
  logic          int_active;

  pipe_ctrl #(.ADDR_W(AW), .RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
    .exc_req(exc_req), .exc_code_in(exc_code_in), .eret_req(eret_req),
    .irq(irq), .int_en(int_en),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .epc(epc), .exc_code(exc_code), .int_active(int_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: "redirecting" while the flush is being broadcast,
  // "settling" for the one cycle after it completes.
  bit            m_redirecting, m_settling;
  logic [AW-1:0] m_new_pc, m_epc;
  logic [2:0]    m_code;
  bit            m_int;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] ret;
    logic [2:0]    code;
    logic          ia;
  } redir_t;
  redir_t sb_q[$];

  task automatic model_reset();
    m_redirecting = 0; m_settling = 0;
    m_new_pc = RV; m_epc = '0; m_code = '0; m_int = 0;
  endtask

  task automatic cycle(input bit rst, input bit ib, input bit mb, input bit ld,
                       input bit me, input logic [AW-1:0] pc, input bit ex,
                       input logic [2:0] code, input bit er, input bit iq, input bit ie);
    bit st, quiet, taken;
    @(negedge clk);
    reset = rst; if_busy = ib; mem_busy = mb; ld_hazard = ld; mem_en = me;
    mem_pc = pc; exc_req = ex; exc_code_in = code; eret_req = er; irq = iq; int_en = ie;
    #1;
    if (rst) model_reset();
    st    = ib | mb;
    quiet = !m_redirecting && !m_settling;
    chk("if_stall",  32'(if_stall),  32'(st | (ld & quiet)));
    chk("id_stall",  32'(id_stall),  32'(st));
    chk("ex_stall",  32'(ex_stall),  32'(st));
    chk("mem_stall", 32'(mem_stall), 32'(st));
    chk("if_flush",  32'(if_flush),  32'(m_redirecting));
    chk("id_flush",  32'(id_flush),  32'(m_redirecting | (quiet & ld & !st)));
    chk("ex_flush",  32'(ex_flush),  32'(m_redirecting));
    chk("mem_flush", 32'(mem_flush), 32'(m_redirecting));
    chk("epc",        32'(epc),        32'(m_epc));
    chk("exc_code",   32'(exc_code),   32'(m_code));
    chk("int_active", 32'(int_active), 32'(m_int));
    if (m_redirecting || rst) chk("new_pc", 32'(new_pc), 32'(m_new_pc));
    if (rst) return;
    // Advance the model to what the next edge should produce.
    taken = 0;
    if (m_redirecting) begin
      if (!st) begin m_redirecting = 0; m_settling = 1; end
    end else if (m_settling) begin
      m_settling = 0;
    end else if (!st && me) begin
      if (ex) begin
        m_epc = pc; m_code = code; m_new_pc = EV; taken = 1;
      end else if (er) begin
        m_new_pc = m_epc; m_int = 0; taken = 1;
      end else if (iq && ie && !m_int) begin
        m_epc = pc; m_code = 3'd1; m_int = 1; m_new_pc = EV; taken = 1;
      end
    end
    if (taken) begin
      m_redirecting = 1;
      sb_q.push_back('{pc: m_new_pc, ret: m_epc, code: m_code, ia: m_int});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, 30'h40, 0, 3'd0, 0, 0, 0);
  endtask

  // Monitor: each new flush burst must match the oldest predicted redirect.
  bit prev_flush = 0;
  initial begin
    redir_t e;
    forever begin
      @(posedge clk); #2;
      if (if_flush && !prev_flush) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL redirect_unexpected: flush seen new_pc %0h, none expected", new_pc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_new_pc",     32'(new_pc),     32'(e.pc));
          chk("sb_epc",        32'(epc),        32'(e.ret));
          chk("sb_exc_code",   32'(exc_code),   32'(e.code));
          chk("sb_int_active", 32'(int_active), 32'(e.ia));
        end
      end
      prev_flush = if_flush;
    end
  end

  initial begin
    int code;
    reset = 1; if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; mem_pc = '0;
    exc_req = 0; exc_code_in = 0; eret_req = 0; irq = 0; int_en = 0;
    model_reset();
    cycle(1, 0, 0, 0, 0, '0, 0, 3'd0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, '0, 0, 3'd0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, '0, 0, 3'd0, 0, 0, 0);
    // Exception with cause 2
    cycle(0, 0, 0, 0, 1, 30'h100, 1, 3'd2, 0, 0, 0);
    idle(3);
    // Exception held by a busy MEM bus for three cycles
    cycle(0, 0, 0, 0, 1, 30'h120, 1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 1, 30'h124, 0, 3'd0, 0, 0, 0);
    idle(3);
    // Interrupt entry, ignored nested irq, return
    cycle(0, 0, 0, 0, 1, 30'h200, 0, 3'd0, 0, 1, 1);
    idle(2);
    cycle(0, 0, 0, 0, 1, 30'h300, 0, 3'd0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 30'h304, 0, 3'd0, 1, 0, 1);
    idle(3);
    // exc and irq together; irq blocked by mem_en=0 and by stall
    cycle(0, 0, 0, 0, 1, 30'h400, 1, 3'd5, 0, 1, 1);
    idle(3);
    cycle(0, 0, 0, 0, 0, 30'h404, 0, 3'd0, 0, 1, 1);
    cycle(0, 1, 0, 0, 1, 30'h408, 0, 3'd0, 0, 1, 1);
    // Reset while flushing
    cycle(0, 0, 0, 0, 1, 30'h500, 1, 3'd6, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 30'h504, 0, 3'd0, 0, 0, 0);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      code = $urandom_range(0, 6);
      if (code >= 1) code++;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), AW'($urandom),
            ($urandom_range(0, 7) == 0), 3'(code), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(4);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_missing: %0d predicted redirects never observed, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
